fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the RISC-V core, directly upstream of the instruction memory. It owns the program counter and drives the memory's word address. The memory returns `Instr` on the falling edge of `CLK`. This block captures `Instr` with its PC into the IF/ID register and hands it to decode over a valid/ready handshake. It also applies control-flow redirects from execute and halts on fetch faults.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be 4-byte aligned.
- `IMEM_WORDS`, default 1024: instruction memory depth in words; legal PCs are 0 .. IMEM_WORDS*4-4.
- `NOP_INSTR`, default 32'h0000_0013: value of `ID_instr` while empty or in reset.

Ports:
- `CLK` in 1: single clock. All state in this block updates on the rising edge.
- `RST` in 1: reset, asynchronous, active-high.
- `Instr` in 32: instruction-memory read data, valid from the falling edge of `CLK` for the current `Address`.
- `Redirect` in 1: execute requests a control-flow change (taken branch, jal, jalr).
- `Target` in 32: redirect destination, sampled when `Redirect`=1.
- `ID_ready` in 1: decode accepts the IF/ID entry this cycle.
- `Address` out 32: byte address to instruction memory; equals PC.
- `ID_valid` out 1: IF/ID entry holds a real instruction.
- `ID_instr` out 32: captured instruction.
- `ID_pc` out 32: PC of `ID_instr`.
- `Halted` out 1: fetch stopped permanently until reset.
- `Fault_code` out 2: 00 none, 01 misaligned redirect target, 10 PC out of range.

## Operation
- FSM states:
  - BOOT: the first rising edge after reset is spent here with no capture, so the memory sees one falling edge on `RESET_PC`. Always goes to RUN.
  - RUN: normal fetch.
  - HALT: absorbing; left only by `RST`.
- Capture condition in RUN: `cap = !ID_valid || ID_ready`.
- Priority within RUN, highest first:
  1. `Redirect` with `Target[1:0]`≠0: PC unchanged, `ID_valid`<=0, go to HALT, `Fault_code`<=01.
  2. `Redirect` aligned: PC<=`Target`, `ID_valid`<=0. This flushes the in-flight entry even if decode is stalled; the stall is ignored.
  3. `cap` with PC ≥ IMEM_WORDS*4: no capture, `ID_valid`<=0, go to HALT, `Fault_code`<=10.
  4. `cap`: `ID_instr`<=`Instr`, `ID_pc`<=PC, `ID_valid`<=1, PC<=PC+4.
  5. Otherwise (stall): PC, `ID_instr`, `ID_pc`, `ID_valid` all held. The memory re-reads the same `Address` every falling edge, so `Instr` stays consistent.
- PC arithmetic: 32-bit unsigned, PC+4 wraps modulo 2^32. The range check (rule 3) catches out-of-range PCs before capture.
- HALT:
  - PC is frozen and no new captures occur.
  - An entry that is already valid stays until decode accepts it (`ID_valid`&&`ID_ready`), then `ID_valid`<=0.
  - `Redirect` is ignored.
  - `Halted`=1 and `Fault_code` holds its value.
- `Redirect` in BOOT is ignored.

## Timing
- Reset values, asserted asynchronously while `RST`=1: state BOOT, PC=`RESET_PC`, `Address`=`RESET_PC`, `ID_valid`=0, `ID_instr`=`NOP_INSTR`, `ID_pc`=0, `Halted`=0, `Fault_code`=00.
- Reset mid-operation discards the IF/ID entry immediately, without waiting for a clock edge.
- `Address` is a registered PC and changes only on the rising edge. It is therefore stable across the falling-edge memory read.
- Fetch latency:
  - PC loaded at rising edge N → `Instr` valid after the falling edge in cycle N → captured at edge N+1.
  - First valid instruction after reset: `ID_valid`=1 after the 2nd rising edge (edge 1 is BOOT).
- Redirect penalty: redirect sampled at edge N → bubble in cycle N+1 → `Target` instruction valid after edge N+1.
- Throughput: one instruction per cycle while `ID_ready`=1.
- `Halted` and `Fault_code` update at the same edge that enters HALT.

## Test plan
- **Reset and boot.** Stimulus: `RESET_PC`=0, memory word0=0x00500093, word1=0x00108113, `ID_ready`=1. Required: `ID_valid`=0 after edge 1; after edge 2, `ID_pc`=0 and `ID_instr`=0x00500093; after edge 3, `ID_pc`=4; `Address` advances 0,4,8.
- **Decode stall.** Stimulus: hold `ID_ready`=0 for 3 cycles while the entry for PC 8 is valid. Required: `Address`, `ID_pc`=8 and `ID_instr` unchanged for all 3 cycles; PC 12 is captured at the first edge after `ID_ready` returns to 1.
- **Redirect during stall.** Stimulus: `Redirect`=1, `Target`=0x40, `ID_ready`=0. Required: `ID_valid`=0 and `Address`=0x40 after that edge; `ID_pc`=0x40 with memory word16 after the next edge.
- **Misaligned redirect.** Stimulus: `Redirect`=1, `Target`=0x42. Required: `Halted`=1, `Fault_code`=01, `Address` unchanged; no further `ID_valid`=1 after any pending entry drains.
- **Out-of-range PC.** Stimulus: redirect to 0xFFC, `ID_ready`=1. Required: 0xFFC is captured; next edge gives `Halted`=1, `Fault_code`=10, `ID_valid`=0, and 0x1000 is never issued.
- **Async reset mid-run.** Stimulus: assert `RST` between clock edges while `ID_valid`=1. Required: `ID_valid`=0, `ID_instr`=0x00000013, `Address`=`RESET_PC` immediately; normal boot sequence follows after deassertion.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory
// address, captures the returned word into the IF/ID register and hands it
// to decode over a valid/ready handshake. Applies redirects from execute
// and halts permanently on a misaligned target or an out-of-range PC.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 1024,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] Instr,
    input  logic        Redirect,
    input  logic [31:0] Target,
    input  logic        ID_ready,
    output logic [31:0] Address,
    output logic        ID_valid,
    output logic [31:0] ID_instr,
    output logic [31:0] ID_pc,
    output logic        Halted,
    output logic [1:0]  Fault_code
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [32:0] PC_END = 33'(IMEM_WORDS) * 33'd4;

    localparam logic [1:0] FAULT_NONE      = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN  = 2'b01;
    localparam logic [1:0] FAULT_RANGE     = 2'b10;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] idpc_q, idpc_d;
    logic [1:0]  fault_q, fault_d;

    logic cap;
    logic out_of_range;

    assign cap          = !valid_q || ID_ready;
    assign out_of_range = {1'b0, pc_q} >= PC_END;

    // State, PC and IF/ID register; reset discards the entry immediately.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            idpc_q  <= '0;
            fault_q <= FAULT_NONE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            idpc_q  <= idpc_d;
            fault_q <= fault_d;
        end
    end

    // Next-state and datapath selection, redirect faults taking priority.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        idpc_d  = idpc_q;
        fault_d = fault_q;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (Redirect && (Target[1:0] != 2'b00)) begin
                    valid_d = 1'b0;
                    state_d = HALT;
                    fault_d = FAULT_MISALIGN;
                end else if (Redirect) begin
                    // Flush even when decode is stalled: the entry is on the wrong path.
                    pc_d    = Target;
                    valid_d = 1'b0;
                end else if (cap && out_of_range) begin
                    valid_d = 1'b0;
                    state_d = HALT;
                    fault_d = FAULT_RANGE;
                end else if (cap) begin
                    instr_d = Instr;
                    idpc_d  = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + 32'd4;
                end
            end
            HALT: begin
                if (valid_q && ID_ready) begin
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    assign Address    = pc_q;
    assign ID_valid   = valid_q;
    assign ID_instr   = instr_q;
    assign ID_pc      = idpc_q;
    assign Halted     = (state_q == HALT);
    assign Fault_code = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a falling-edge instruction memory
// model plus a cycle-level reference of the fetch rules.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int unsigned WORDS  = 1024;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        CLK;
    logic        RST;
    logic [31:0] Instr;
    logic        Redirect;
    logic [31:0] Target;
    logic        ID_ready;
    logic [31:0] Address;
    logic        ID_valid;
    logic [31:0] ID_instr;
    logic [31:0] ID_pc;
    logic        Halted;
    logic [1:0]  Fault_code;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:WORDS-1];

    // reference model state
    bit          m_boot;
    bit          m_halt;
    bit          m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_idpc;
    logic [1:0]  m_fault;

    fetch_unit #(
        .RESET_PC  (RST_PC),
        .IMEM_WORDS(WORDS),
        .NOP_INSTR (NOP)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .Instr     (Instr),
        .Redirect  (Redirect),
        .Target    (Target),
        .ID_ready  (ID_ready),
        .Address   (Address),
        .ID_valid  (ID_valid),
        .ID_instr  (ID_instr),
        .ID_pc     (ID_pc),
        .Halted    (Halted),
        .Fault_code(Fault_code)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] memrd(input logic [31:0] a);
        if (longint'(a) < longint'(WORDS) * 4) return mem[a[31:2]];
        return 32'hBAD0_BAD0;
    endfunction

    // memory answers on the falling edge for the current address
    initial Instr = '0;
    always @(negedge CLK) Instr = memrd(Address);

    task automatic model_reset();
        m_boot  = 1;
        m_halt  = 0;
        m_valid = 0;
        m_pc    = RST_PC;
        m_instr = NOP;
        m_idpc  = '0;
        m_fault = 2'b00;
    endtask

    // advance one rising edge, updating the reference from the sampled inputs
    task automatic step();
        bit cap;
        @(posedge CLK);
        if (m_boot) begin
            m_boot = 0;
        end else if (!m_halt) begin
            cap = !m_valid || ID_ready;
            if (Redirect && (Target % 4 != 0)) begin
                m_valid = 0; m_halt = 1; m_fault = 2'b01;
            end else if (Redirect) begin
                m_pc = Target; m_valid = 0;
            end else if (cap && longint'(m_pc) >= longint'(WORDS) * 4) begin
                m_valid = 0; m_halt = 1; m_fault = 2'b10;
            end else if (cap) begin
                m_instr = memrd(m_pc); m_idpc = m_pc; m_valid = 1; m_pc = m_pc + 4;
            end
        end else if (m_valid && ID_ready) begin
            m_valid = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        Redirect = 1'b0;
        Target = '0;
        ID_ready = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        RST = 1'b1;
        Redirect = 1'b0;
        Target = '0;
        ID_ready = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        checks++; if (Address !== RST_PC) begin errors++; $display("FAIL reset_addr: got %h want %h", Address, RST_PC); end
        checks++; if (ID_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ID_valid); end
        checks++; if (ID_instr !== NOP) begin errors++; $display("FAIL reset_instr: got %h want %h", ID_instr, NOP); end
        checks++; if (ID_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", ID_pc); end
        checks++; if (Halted !== 1'b0 || Fault_code !== 2'b00) begin errors++; $display("FAIL reset_fault: got %b/%b want 0/00", Halted, Fault_code); end
        RST = 1'b0;
        model_reset();
        step();
        checks++; if (ID_valid !== 1'b0 || Address !== 32'h0) begin errors++; $display("FAIL boot_edge1: got v=%b a=%h want v=0 a=0", ID_valid, Address); end
        step();
        checks++; if (ID_valid !== 1'b1 || ID_pc !== 32'h0 || ID_instr !== 32'h0050_0093) begin errors++; $display("FAIL boot_edge2: got v=%b pc=%h i=%h want v=1 pc=0 i=00500093", ID_valid, ID_pc, ID_instr); end
        checks++; if (Address !== 32'h4) begin errors++; $display("FAIL boot_addr4: got %h want 4", Address); end
        step();
        checks++; if (ID_pc !== 32'h4 || ID_instr !== 32'h0010_8113 || Address !== 32'h8) begin errors++; $display("FAIL boot_edge3: got pc=%h i=%h a=%h want 4 00108113 8", ID_pc, ID_instr, Address); end
    endtask

    task automatic test_stall();
        step();
        checks++; if (ID_pc !== 32'h8 || ID_valid !== 1'b1 || Address !== 32'hC) begin errors++; $display("FAIL stall_pre: got pc=%h v=%b a=%h want 8 1 c", ID_pc, ID_valid, Address); end
        ID_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (Address !== 32'hC || ID_pc !== 32'h8 || ID_instr !== mem[2] || ID_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold%0d: got a=%h pc=%h i=%h v=%b want c 8 %h 1", i, Address, ID_pc, ID_instr, ID_valid, mem[2]);
            end
        end
        ID_ready = 1'b1;
        step();
        checks++; if (ID_pc !== 32'hC || ID_instr !== mem[3] || Address !== 32'h10) begin errors++; $display("FAIL stall_release: got pc=%h i=%h a=%h want c %h 10", ID_pc, ID_instr, Address, mem[3]); end
    endtask

    task automatic test_redirect_stall();
        ID_ready = 1'b0;
        Redirect = 1'b1;
        Target = 32'h40;
        step();
        checks++; if (ID_valid !== 1'b0 || Address !== 32'h40) begin errors++; $display("FAIL redir_flush: got v=%b a=%h want 0 40", ID_valid, Address); end
        Redirect = 1'b0;
        ID_ready = 1'b1;
        step();
        checks++; if (ID_valid !== 1'b1 || ID_pc !== 32'h40 || ID_instr !== mem[16]) begin errors++; $display("FAIL redir_target: got v=%b pc=%h i=%h want 1 40 %h", ID_valid, ID_pc, ID_instr, mem[16]); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            Redirect = ($urandom_range(7) == 0);
            Target = {20'h0, 12'($urandom_range(511)) << 2};
            ID_ready = ($urandom_range(3) != 0);
            step();
            checks++; if (Address !== m_pc) begin errors++; $display("FAIL rnd_addr c%0d: got %h want %h", c, Address, m_pc); end
            checks++; if (ID_valid !== m_valid) begin errors++; $display("FAIL rnd_valid c%0d: got %b want %b", c, ID_valid, m_valid); end
            if (m_valid) begin
                checks++;
                if (ID_pc !== m_idpc || ID_instr !== m_instr) begin
                    errors++;
                    $display("FAIL rnd_entry c%0d: got pc=%h i=%h want pc=%h i=%h", c, ID_pc, ID_instr, m_idpc, m_instr);
                end
            end
            checks++; if (Halted !== m_halt || Fault_code !== m_fault) begin errors++; $display("FAIL rnd_fault c%0d: got %b/%b want %b/%b", c, Halted, Fault_code, m_halt, m_fault); end
        end
        Redirect = 1'b0;
    endtask

    task automatic test_misaligned();
        logic [31:0] addr_before;
        ID_ready = 1'b0;
        step();
        addr_before = m_pc;
        Redirect = 1'b1;
        Target = 32'h42;
        step();
        checks++; if (Halted !== 1'b1 || Fault_code !== 2'b01) begin errors++; $display("FAIL mis_fault: got %b/%b want 1/01", Halted, Fault_code); end
        checks++; if (Address !== addr_before || ID_valid !== 1'b0) begin errors++; $display("FAIL mis_freeze: got a=%h v=%b want a=%h v=0", Address, ID_valid, addr_before); end
        Redirect = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ID_ready = $urandom_range(1);
            Redirect = (i == 2);
            Target = 32'h80;
            step();
            checks++;
            if (ID_valid !== 1'b0 || Address !== addr_before || Halted !== 1'b1 || Fault_code !== 2'b01) begin
                errors++;
                $display("FAIL mis_halt%0d: got v=%b a=%h h=%b f=%b want 0 %h 1 01", i, ID_valid, Address, Halted, Fault_code, addr_before);
            end
        end
        Redirect = 1'b0;
    endtask

    task automatic test_out_of_range();
        do_reset();
        repeat (3) step();
        Redirect = 1'b1;
        Target = 32'hFFC;
        ID_ready = 1'b1;
        step();
        Redirect = 1'b0;
        checks++; if (Address !== 32'hFFC || ID_valid !== 1'b0) begin errors++; $display("FAIL oor_redir: got a=%h v=%b want ffc 0", Address, ID_valid); end
        step();
        checks++; if (ID_valid !== 1'b1 || ID_pc !== 32'hFFC || ID_instr !== mem[WORDS-1]) begin errors++; $display("FAIL oor_last: got v=%b pc=%h i=%h want 1 ffc %h", ID_valid, ID_pc, ID_instr, mem[WORDS-1]); end
        step();
        checks++; if (Halted !== 1'b1 || Fault_code !== 2'b10 || ID_valid !== 1'b0) begin errors++; $display("FAIL oor_halt: got h=%b f=%b v=%b want 1 10 0", Halted, Fault_code, ID_valid); end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (ID_valid !== 1'b0 || Address !== 32'h1000 || Halted !== 1'b1) begin
                errors++;
                $display("FAIL oor_stay%0d: got v=%b a=%h h=%b want 0 1000 1", i, ID_valid, Address, Halted);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        ID_ready = 1'b1;
        repeat (5) step();
        checks++; if (ID_valid !== 1'b1) begin errors++; $display("FAIL arst_pre: got v=%b want 1", ID_valid); end
        #2;
        RST = 1'b1;
        #1;
        checks++; if (ID_valid !== 1'b0 || ID_instr !== NOP || Address !== RST_PC) begin errors++; $display("FAIL arst_now: got v=%b i=%h a=%h want 0 %h %h", ID_valid, ID_instr, Address, NOP, RST_PC); end
        @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (Address !== m_pc || ID_valid !== m_valid || (m_valid && (ID_pc !== m_idpc || ID_instr !== m_instr))) begin
                errors++;
                $display("FAIL arst_boot%0d: got a=%h v=%b pc=%h i=%h want a=%h v=%b pc=%h i=%h", i, Address, ID_valid, ID_pc, ID_instr, m_pc, m_valid, m_idpc, m_instr);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int unsigned i = 0; i < WORDS; i++) mem[i] = $urandom;
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h0010_8113;
        test_reset();
        test_stall();
        test_redirect_stall();
        test_random();
        test_misaligned();
        test_out_of_range();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
